// File: rtl/deathrace_pkg.sv
// ----------------------------------------------------------------------------
// deathrace_pkg
//   Shared constants and types for the Death Race sprite/game-logic blocks.
//   Holds the VGA bus macros, sprite geometry (gremlin 16x32, car defaults),
//   the score limit, and the gremlin life-cycle state type.
//   Ports: none (package).
// ----------------------------------------------------------------------------

`ifndef DEATHRACE_VGA_MACROS
`define DEATHRACE_VGA_MACROS
`define VGA_COORD_W 11
`define VGA_RGB_W   12
`define VGA_BUS_W   (2*`VGA_COORD_W + `VGA_RGB_W + 2)
`endif

package deathrace_pkg;

    // Screen coordinate width shared by every sprite position bus.
    localparam int COORD_W    = `VGA_COORD_W;

    // Gremlin sprite footprint.
    localparam int GREM_W     = 16;
    localparam int GREM_H     = 32;

    // Default car sprite footprint.
    localparam int CAR_W_DEF  = 32;
    localparam int CAR_H_DEF  = 32;

    // Kill counter: 10-bit binary, saturating at three decimal digits.
    localparam int SCORE_W    = 10;
    localparam int SCORE_MAX  = 999;

    // Per-state frame counter width.
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        SPAWN = 2'd0,
        ALIVE = 2'd1,
        SPLAT = 2'd2,
        DEAD  = 2'd3
    } life_state_e;

    // Increment that sticks at SCORE_MAX.
    function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
        return (v == SCORE_W'(SCORE_MAX)) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hit_box_cmp.sv
// ----------------------------------------------------------------------------
// hit_box_cmp
//   Pure combinational axis-aligned box overlap test between box A (top-left
//   a_x/a_y, size A_W x A_H) and box B (top-left b_x/b_y, size B_W x B_H).
//   Edges that merely touch do not count as overlap. Sums are formed one bit
//   wider than the coordinates so a box near the right/bottom limit cannot
//   wrap around and fake an overlap.
//   Ports:
//     a_x, a_y  in   box A top-left
//     b_x, b_y  in   box B top-left
//     overlap   out  1 when the two boxes share at least one pixel
// ----------------------------------------------------------------------------
module hit_box_cmp
    import deathrace_pkg::*;
#(
    parameter int POS_W = COORD_W,
    parameter int A_W   = CAR_W_DEF,
    parameter int A_H   = CAR_H_DEF,
    parameter int B_W   = GREM_W,
    parameter int B_H   = GREM_H
) (
    input  logic [POS_W-1:0] a_x,
    input  logic [POS_W-1:0] a_y,
    input  logic [POS_W-1:0] b_x,
    input  logic [POS_W-1:0] b_y,
    output logic             overlap
);

    localparam int SUM_W = POS_W + 1;

    logic [SUM_W-1:0] ax, ay, bx, by;

    assign ax = {1'b0, a_x};
    assign ay = {1'b0, a_y};
    assign bx = {1'b0, b_x};
    assign by = {1'b0, b_y};

    assign overlap = (bx < ax + SUM_W'(A_W)) &&
                     (ax < bx + SUM_W'(B_W)) &&
                     (by < ay + SUM_W'(A_H)) &&
                     (ay < by + SUM_W'(B_H));

endmodule

// File: rtl/grem_life_ctl.sv
// ----------------------------------------------------------------------------
// grem_life_ctl
//   Gremlin life cycle: SPAWN -> ALIVE -> (run over) SPLAT -> DEAD -> ALIVE.
//   All state, counter, tombstone and score updates happen on frame ticks
//   (en=1); only the one-clk hit pulse clears regardless of en.
//   Optional feature: define GREM_SCORE_EN to build the saturating kill
//   counter; without it score is tied to zero and no register is built.
//   Ports:
//     clk          in   system clock
//     rst          in   synchronous active-high reset
//     en           in   frame tick, one clk per frame
//     car_x/car_y  in   car top-left
//     grem_x/y     in   gremlin top-left
//     grem_enable  out  1 while the gremlin roams (ALIVE)
//     hit          out  one-clk pulse per kill
//     tomb_valid   out  tombstone shown (SPLAT)
//     tomb_x/y     out  tombstone position, held until the next kill
//     score        out  kill count
// ----------------------------------------------------------------------------
module grem_life_ctl
    import deathrace_pkg::*;
#(
    parameter int CAR_W          = CAR_W_DEF,
    parameter int CAR_H          = CAR_H_DEF,
    parameter int SPLAT_FRAMES   = 60,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [COORD_W-1:0] car_x,
    input  logic [COORD_W-1:0] car_y,
    input  logic [COORD_W-1:0] grem_x,
    input  logic [COORD_W-1:0] grem_y,
    output logic               grem_enable,
    output logic               hit,
    output logic               tomb_valid,
    output logic [COORD_W-1:0] tomb_x,
    output logic [COORD_W-1:0] tomb_y,
    output logic [SCORE_W-1:0] score
);

    // Terminal counts: a value of N keeps the state for exactly N ticks.
    localparam logic [CNT_W-1:0] SPLAT_LAST   = CNT_W'(SPLAT_FRAMES - 1);
    localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);

    life_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               kill;
    logic               overlap;
    logic               hit_q;
    logic [COORD_W-1:0] tomb_x_q, tomb_y_q;

    hit_box_cmp #(
        .POS_W (COORD_W),
        .A_W   (CAR_W),
        .A_H   (CAR_H),
        .B_W   (GREM_W),
        .B_H   (GREM_H)
    ) u_hit_box (
        .a_x     (car_x),
        .a_y     (car_y),
        .b_x     (grem_x),
        .b_y     (grem_y),
        .overlap (overlap)
    );

    // Next-state and counter logic. Overlap is only consulted in ALIVE, and
    // leaving ALIVE on the kill tick guarantees one hit per ALIVE period.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        kill    = 1'b0;
        if (en) begin
            case (state_q)
                SPAWN: begin
                    state_d = ALIVE;
                    cnt_d   = '0;
                end
                ALIVE: begin
                    if (overlap) begin
                        state_d = SPLAT;
                        cnt_d   = '0;
                        kill    = 1'b1;
                    end
                end
                SPLAT: begin
                    if (cnt_q == SPLAT_LAST) begin
                        state_d = DEAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DEAD: begin
                    if (cnt_q == RESPAWN_LAST) begin
                        state_d = ALIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SPAWN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SPAWN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Kill side effects: the pulse follows the kill decision every clk, so it
    // drops by itself one clk later even when en stays low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q    <= 1'b0;
            tomb_x_q <= '0;
            tomb_y_q <= '0;
        end else begin
            hit_q <= kill;
            if (kill) begin
                tomb_x_q <= grem_x;
                tomb_y_q <= grem_y;
            end
        end
    end

`ifdef GREM_SCORE_EN
    logic [SCORE_W-1:0] score_q;

    // Bumps on the same edge that raises hit, so both are seen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
        end else if (kill) begin
            score_q <= score_inc(score_q);
        end
    end

    assign score = score_q;
`else
    assign score = '0;
`endif

    assign grem_enable = (state_q == ALIVE);
    assign tomb_valid  = (state_q == SPLAT);
    assign hit         = hit_q;
    assign tomb_x      = tomb_x_q;
    assign tomb_y      = tomb_y_q;

endmodule

// File: tb/tb_grem_life_ctl.sv
// ----------------------------------------------------------------------------
// tb_grem_life_ctl
//   Directed bench for grem_life_ctl. A default-parameter instance covers the
//   life cycle, touch edges, hold on en=0 and reset priority; a second
//   instance with 1-tick SPLAT/DEAD drives 1000+ kills to reach the score
//   limit. Expected score depends on whether GREM_SCORE_EN is defined.
// ----------------------------------------------------------------------------
module tb_grem_life_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        en_f;
    logic [10:0] car_x, car_y, grem_x, grem_y;

    logic        grem_enable, hit, tomb_valid;
    logic [10:0] tomb_x, tomb_y;
    logic [9:0]  score;

    logic        grem_enable_f, hit_f, tomb_valid_f;
    logic [10:0] tomb_x_f, tomb_y_f;
    logic [9:0]  score_f;

`ifdef GREM_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int exp_score = 0;

    always #5 clk = ~clk;

    grem_life_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .car_x       (car_x),
        .car_y       (car_y),
        .grem_x      (grem_x),
        .grem_y      (grem_y),
        .grem_enable (grem_enable),
        .hit         (hit),
        .tomb_valid  (tomb_valid),
        .tomb_x      (tomb_x),
        .tomb_y      (tomb_y),
        .score       (score)
    );

    grem_life_ctl #(
        .SPLAT_FRAMES   (1),
        .RESPAWN_FRAMES (1)
    ) dut_fast (
        .clk         (clk),
        .rst         (rst),
        .en          (en_f),
        .car_x       (car_x),
        .car_y       (car_y),
        .grem_x      (grem_x),
        .grem_y      (grem_y),
        .grem_enable (grem_enable_f),
        .hit         (hit_f),
        .tomb_valid  (tomb_valid_f),
        .tomb_x      (tomb_x_f),
        .tomb_y      (tomb_y_f),
        .score       (score_f)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One frame tick on the main instance; outputs are stable on return.
    task automatic tick();
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_kill();
        if (SCORE_ON && exp_score < 999) exp_score++;
    endtask

    int edge_x [4] = '{132, 84, 100, 100};
    int edge_y [4] = '{200, 200, 232, 168};

    initial begin
        int splat_n, ticks, hits, nh;

        rst = 1'b1; en = 1'b0; en_f = 1'b0;
        car_x = 11'd100; car_y = 11'd200;
        grem_x = 11'd400; grem_y = 11'd400;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_grem_enable", grem_enable, 0);
        check("rst_hit", hit, 0);
        check("rst_tomb_valid", tomb_valid, 0);
        check("rst_tomb_x", tomb_x, 0);
        check("rst_tomb_y", tomb_y, 0);
        check("rst_score", score, 0);

        // SPAWN holds grem_enable low until the first tick.
        idle();
        check("spawn_hold_en0", grem_enable, 0);
        tick();
        check("spawn_to_alive", grem_enable, 1);
        check("alive_score", score, 0);
        check("alive_tomb_valid", tomb_valid, 0);

        // Boxes that only touch on one edge must not kill.
        for (int i = 0; i < 4; i++) begin
            grem_x = 11'(edge_x[i]);
            grem_y = 11'(edge_y[i]);
            tick();
            check($sformatf("touch_nohit_%0d", i), hit, 0);
            check($sformatf("touch_alive_%0d", i), grem_enable, 1);
        end

        // One pixel of overlap kills.
        grem_x = 11'd131; grem_y = 11'd200;
        tick();
        model_kill();
        check("edge_hit", hit, 1);
        check("edge_tomb_x", tomb_x, 131);
        check("edge_tomb_y", tomb_y, 200);
        check("edge_tomb_valid", tomb_valid, 1);
        check("edge_grem_enable", grem_enable, 0);
        check("edge_score", score, exp_score);
        idle();
        check("edge_hit_clear", hit, 0);

        // Full SPLAT + DEAD with overlap held, including an en=0 pause.
        splat_n = 0; ticks = 0; hits = 0;
        while (!grem_enable && ticks < 400) begin
            if (tomb_valid) splat_n++;
            tick();
            ticks++;
            if (hit) hits++;
            if (ticks == 10) repeat (3) idle();
        end
        check("splat_ticks", splat_n, 60);
        check("respawn_ticks", ticks, 180);
        check("no_second_hit", hits, 0);
        check("tomb_x_hold", tomb_x, 131);
        check("tomb_y_hold", tomb_y, 200);
        check("respawn_tomb_valid", tomb_valid, 0);
        check("respawn_score", score, exp_score);

        // Interior overlap.
        grem_x = 11'd110; grem_y = 11'd210;
        tick();
        model_kill();
        check("kill2_hit", hit, 1);
        check("kill2_tomb_x", tomb_x, 110);
        check("kill2_tomb_y", tomb_y, 210);
        check("kill2_tomb_valid", tomb_valid, 1);
        check("kill2_grem_enable", grem_enable, 0);
        check("kill2_score", score, exp_score);
        idle();
        check("kill2_hit_clear", hit, 0);

        // Into DEAD, tick 50, then reset with en also high.
        repeat (60 + 50) tick();
        check("dead_tomb_valid", tomb_valid, 0);
        check("dead_grem_enable", grem_enable, 0);
        @(negedge clk);
        rst = 1'b1; en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; en = 1'b0;
        exp_score = 0;
        check("rst_dead_grem_enable", grem_enable, 0);
        check("rst_dead_tomb_valid", tomb_valid, 0);
        check("rst_dead_tomb_x", tomb_x, 0);
        check("rst_dead_tomb_y", tomb_y, 0);
        check("rst_dead_score", score, 0);
        check("rst_dead_hit", hit, 0);
        tick();
        check("rst_respawn", grem_enable, 1);
        check("spawn_overlap_ignored", hit, 0);
        tick();
        model_kill();
        check("post_rst_hit", hit, 1);
        check("post_rst_score", score, exp_score);

        // Score limit on the fast instance: kill n lands on tick 3n-1.
        nh = 0;
        @(negedge clk);
        en_f = 1'b1;
        for (int i = 0; i < 3010; i++) begin
            @(posedge clk);
            #1;
            if (hit_f) begin
                nh++;
                if (nh == 500) check("fast_score_500", score_f, SCORE_ON ? 500 : 0);
            end
        end
        en_f = 1'b0;
        check("fast_kills", nh, 1003);
        check("fast_score_sat", score_f, SCORE_ON ? 999 : 0);
        idle();
        check("fast_hit_clear", hit_f, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
